data_mem_param: RTL and testbench
=================================

# data_mem_param

Parametrised word-addressed data memory for the bubble-sort datapath. It replaces the fixed 32×32 store with configurable width and depth, per-byte write enables and a valid/ready request port. Every request gets a registered one-cycle response with an out-of-range error flag. The block also has a hardware zero-fill sequencer that runs after reset or on a clear command, and a read-bypass path that substitutes register-file data for memory data on demand.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 32, number of words; any value ≥ 2
- ADDR_W, $clog2(DEPTH), internal index width
- INIT_ZERO, 1, 1 = zero-fill after reset/clear; 0 = skip fill

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  one-cycle pulse that requests a re-zero-fill (honoured in IDLE only)
- req_valid  in  1  request present
- req_ready  out  1  block can accept; equals (state==IDLE) && !clear
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  word index (not a byte address)
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i]
- bypass_sel  in  1  read returns bypass_data instead of memory
- bypass_data  in  DATA_W  bypass value
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  response data
- rsp_err  out  1  address was out of range
- init_done  out  1  fill complete; level signal

## Operation
- States: INIT and IDLE.
- Reset:
  - state = INIT if INIT_ZERO=1, otherwise IDLE.
  - fill counter = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - init_done = 0 if INIT_ZERO=1, otherwise 1.
- INIT:
  - Each clock writes 0 to word[counter] and increments the counter.
  - On the edge that writes word DEPTH-1: state goes to IDLE, init_done goes to 1, counter goes to 0.
  - req_ready = 0 throughout; clear is ignored.
- IDLE, clear=1:
  - If INIT_ZERO=1: next state is INIT and init_done drops to 0.
  - If INIT_ZERO=0: clear has no effect.
  - A req_valid in the same cycle is not accepted, because req_ready = 0.
- A request is accepted on an edge where req_valid && req_ready.
- Range check: the request is in range when req_addr < DEPTH, compared on all 32 bits.
- Accepted write, in range:
  - word = (old & ~mask) | (req_wdata & mask), where mask is expanded from req_be.
  - Response: rdata = merged word, err = 0.
- Accepted write, out of range: memory is unchanged; rdata = 0, err = 1.
- Accepted read, bypass_sel=1: rdata = bypass_data sampled at acceptance; err = 0; no range check and no memory access.
- Accepted read, bypass_sel=0, in range: rdata = word[req_addr]; err = 0.
- Accepted read, bypass_sel=0, out of range: rdata = 0; err = 1.
- No request accepted this cycle: the next rsp_valid is 0. rsp_rdata and rsp_err hold their last values.

## Timing
- Response latency is exactly 1 cycle. rsp_* are registered and update on the edge after acceptance; rsp_valid stays high for 1 cycle.
- Throughput is one request per cycle in IDLE. There is no response backpressure.
- Write then read of the same word on consecutive cycles: the read returns the newly written value.
- Fill time: init_done rises DEPTH clock edges after rst_n deasserts, or after the clear edge.
- rst_n asserted mid-INIT: fill restarts from word 0 after release. Any in-flight response is squashed (rsp_valid = 0).
- Memory contents are not altered by rst_n itself; only the fill sequence clears them.

## Test plan
- Fill check (DEPTH=32, INIT_ZERO=1): release reset → req_ready=0 for 32 cycles, then init_done=1. Reads of words 0..31 each return 0 with err=0.
- Full write/readback: write 0x0000_0004 to addr 3 with be=4'hF, then read addr 3 on the next cycle → write response rdata=0x0000_0004; read response rdata=0x0000_0004 exactly 1 cycle after acceptance.
- Byte merge: word 5 holds 0x1122_3344; write 0xAABB_CCDD with be=4'b0010 → response and later read = 0x1122_CC44.
- Out of range:
  - Read addr 32 → rsp_err=1, rdata=0.
  - Write 0xFFFF_FFFF to addr 0x8000_0000 → rsp_err=1, and no word changes.
- Bypass: read addr 7 with bypass_sel=1 and bypass_data=0xDEAD_BEEF → rdata=0xDEAD_BEEF, err=0, memory untouched.
- Clear/reset collisions:
  - clear together with req_valid → request not accepted and no rsp_valid. Then 32 cycles of INIT, after which all words read 0.
  - rst_n pulsed at fill cycle 10 → init_done rises 32 edges after the pulse is released.

Source files
------------

// File: rtl/data_mem_param.sv
// Parametrised word-addressed data memory with byte enables, a valid/ready request port,
// registered one-cycle responses, a hardware zero-fill sequencer and a read-bypass path.
module data_mem_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic                bypass_sel,
  input  logic [DATA_W-1:0]   bypass_data,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fill_cnt_reg, fill_cnt_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] req_idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] merged_word;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  logic              rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_next;
  logic              rsp_err_next;

  assign req_ready = (state_reg == ST_IDLE) && !clear;
  assign init_done = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign in_range  = req_addr < 32'(DEPTH);
  assign req_idx   = req_addr[ADDR_W-1:0];
  assign old_word  = in_range ? mem[req_idx] : '0;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_mask
    assign be_mask[8*gi +: 8] = {8{req_be[gi]}};
  end

  assign merged_word = (old_word & ~be_mask) | (req_wdata & be_mask);

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        fill_cnt_next = fill_cnt_reg + ADDR_W'(1);
        if (fill_cnt_reg == LAST_IDX) begin
          state_next    = ST_IDLE;
          fill_cnt_next = '0;
        end
      end
      ST_IDLE: begin
        if (clear && (INIT_ZERO != 0)) begin
          state_next    = ST_INIT;
          fill_cnt_next = '0;
        end
      end
      default: state_next = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RST_STATE;
      fill_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  // The fill sequencer owns the write port while in INIT; requests cannot be accepted then.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_wdata = req_wdata;
    mem_be    = req_be;
    if (state_reg == ST_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = fill_cnt_reg;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (accept && req_we && in_range) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array: contents survive rst_n and are cleared only by the fill.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_valid_next = accept;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;
    if (accept) begin
      if (req_we) begin
        rsp_rdata_next = in_range ? merged_word : '0;
        rsp_err_next   = !in_range;
      end else if (bypass_sel) begin
        rsp_rdata_next = bypass_data;
        rsp_err_next   = 1'b0;
      end else begin
        rsp_rdata_next = in_range ? old_word : '0;
        rsp_err_next   = !in_range;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: randomized and directed requests are modelled with
// a plain array; a monitor pops expected responses and checks data, error flag and latency.
module tb_data_mem_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        bypass_sel;
  logic [31:0] bypass_data;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  data_mem_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .bypass_sel(bypass_sel), .bypass_data(bypass_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard, one cycle after acceptance.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp actual=%h required=none", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rsp cyc=%0d rdata=%h err=%0b", cyc, rsp_rdata, rsp_err);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_latency", cyc, e.cyc);
      end
    end
  end

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endfunction

  // Called at a negedge; drives one request for one cycle and records the expected response.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic bs, input logic [31:0] bd);
    exp_t        e;
    logic [31:0] w;
    req_valid   = 1'b1;
    req_we      = we;
    req_addr    = a;
    req_wdata   = d;
    req_be      = be;
    bypass_sel  = bs;
    bypass_data = bd;
    if (req_ready) begin
      e.cyc = cyc + 1;
      if (we) begin
        if (a < DEPTH) begin
          w = model_mem[a];
          for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
          model_mem[a] = w;
          e.rdata = w;
          e.err   = 1'b0;
        end else begin
          e.rdata = '0;
          e.err   = 1'b1;
        end
      end else if (bs) begin
        e.rdata = bd;
        e.err   = 1'b0;
      end else if (a < DEPTH) begin
        e.rdata = model_mem[a];
        e.err   = 1'b0;
      end else begin
        e.rdata = '0;
        e.err   = 1'b1;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(i), '0, '0, 1'b0, '0);
  endtask

  // Counts edges until init_done rises and how many of those cycles showed req_ready high.
  task automatic wait_init(output int n, output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    while (!init_done && n < 200) begin
      if (req_ready) rdy_hi++;
      @(posedge clk);
      n++;
      #1;
    end
    @(negedge clk);
  endtask

  int          n_edges;
  int          n_rdy;
  logic [31:0] a;

  initial begin
    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; bypass_sel = 1'b0; bypass_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    rst_n = 1'b1;
    wait_init(n_edges, n_rdy);
    check("fill_edges", n_edges, 32'd32);
    check("fill_ready_low", n_rdy, 32'd0);
    model_zero();
    read_all();

    // Directed: full write/readback, byte merge, out of range, bypass.
    issue(1'b1, 32'd3, 32'h0000_0004, 4'hF, 1'b0, '0);
    issue(1'b0, 32'd3, '0, '0, 1'b0, '0);
    issue(1'b1, 32'd5, 32'h1122_3344, 4'hF, 1'b0, '0);
    issue(1'b1, 32'd5, 32'hAABB_CCDD, 4'b0010, 1'b0, '0);
    issue(1'b0, 32'd5, '0, '0, 1'b0, '0);
    issue(1'b0, 32'd32, '0, '0, 1'b0, '0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, '0);
    issue(1'b0, 32'd7, '0, '0, 1'b1, 32'hDEAD_BEEF);
    read_all();

    // Randomized mix, including idle gaps, partial byte enables and out-of-range addresses.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
      end else begin
        a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
        issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0), $urandom);
      end
    end
    read_all();

    // Clear colliding with a request: request must not be accepted, then a full re-fill.
    clear = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd3; bypass_sel = 1'b0;
    #1;
    check("clear_blocks_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    req_valid = 1'b0;
    check("clear_init_done_low", 32'(init_done), 32'd0);
    wait_init(n_edges, n_rdy);
    check("clear_fill_edges", n_edges, 32'd32);
    model_zero();
    read_all();

    // Put some data back, then reset in the middle of a fill.
    for (int i = 0; i < 8; i++) issue(1'b1, 32'($urandom_range(0, DEPTH - 1)), $urandom, 4'hF, 1'b0, '0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midfill_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midfill_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n_edges, n_rdy);
    check("midfill_fill_edges", n_edges, 32'd32);
    model_zero();
    read_all();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
